dircc_stream_arbiter: RTL

Packet-locked round-robin arbiter sharing one Avalon-ST routing link between `NUM_INPUTS` processing-node output streams. Each input is a `stream_out_*` interface of a `dircc_nios_processing` node. The single output feeds the routing fabric. A grant is held from the start-of-packet beat to the end-of-packet beat, so packets are never interleaved. Beats arriving outside a packet are discarded and counted. Output is registered (one pipeline stage).

---
 rtl/dircc_stream_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/dircc_stream_arbiter.sv
// ---- dircc_stream_arbiter: packet-locked round-robin Avalon-ST arbiter, registered output (rev 1.0) ----
`default_nettype none

module dircc_stream_arbiter #(
  parameter int NUM_INPUTS  = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int EMPTY_WIDTH = 2
) (
  input  logic                              clk_clk,
  input  logic                              reset_reset_n,
  input  logic [NUM_INPUTS-1:0]             stream_in_valid,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0]  stream_in_data,
  input  logic [NUM_INPUTS-1:0]             stream_in_startofpacket,
  input  logic [NUM_INPUTS-1:0]             stream_in_endofpacket,
  input  logic [NUM_INPUTS*EMPTY_WIDTH-1:0] stream_in_empty,
  output logic [NUM_INPUTS-1:0]             stream_in_ready,
  output logic                              stream_out_valid,
  output logic [DATA_WIDTH-1:0]             stream_out_data,
  output logic                              stream_out_startofpacket,
  output logic                              stream_out_endofpacket,
  output logic [EMPTY_WIDTH-1:0]            stream_out_empty,
  input  logic                              stream_out_ready,
  output logic [NUM_INPUTS-1:0]             grant,
  output logic                              busy,
  output logic [15:0]                       drop_count
);

  localparam int PTR_W = $clog2(NUM_INPUTS);
  localparam logic [PTR_W:0] NUM_N = (PTR_W+1)'(NUM_INPUTS);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_INPUTS - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, PKT = 1'b1} state_t;

  state_t                state, state_nx;
  logic [PTR_W-1:0]      ptr, ptr_nx, owner, owner_nx, pick;
  logic                  pick_ok;
  logic [PTR_W:0]        idx;
  logic [NUM_INPUTS-1:0] grant_nx, cand, stray;
  logic                  slot_free, fwd;
  logic [3:0]            stray_cnt;
  logic [16:0]           drop_sum;

  assign slot_free = !stream_out_valid || stream_out_ready;
  assign cand      = stream_in_valid & stream_in_startofpacket;
  assign busy      = (state == PKT);

  // Scan downward so the candidate closest to ptr is the last (winning) assignment.
  always_comb begin : pick_logic
    pick    = '0;
    pick_ok = 1'b0;
    idx     = '0;
    for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
      idx = {1'b0, ptr} + (PTR_W+1)'(k);
      if (idx >= NUM_N) idx = idx - NUM_N;
      if (cand[idx[PTR_W-1:0]]) begin
        pick    = idx[PTR_W-1:0];
        pick_ok = 1'b1;
      end
    end
  end

  always_comb begin : ctrl_logic
    state_nx        = state;
    ptr_nx          = ptr;
    owner_nx        = owner;
    grant_nx        = grant;
    stream_in_ready = '0;
    stray           = '0;
    fwd             = 1'b0;
    if (reset_reset_n) begin
      case (state)
        IDLE: begin
          // Ready here does not look at valid; SOP holders wait for the grant.
          stream_in_ready = ~stream_in_startofpacket;
          stray           = stream_in_valid & ~stream_in_startofpacket;
          if (pick_ok) begin
            state_nx = PKT;
            owner_nx = pick;
            grant_nx = NUM_INPUTS'(1) << pick;
          end
        end
        PKT: begin
          stream_in_ready[owner] = slot_free;
          fwd = stream_in_valid[owner] && slot_free;
          if (fwd && stream_in_endofpacket[owner]) begin
            state_nx = IDLE;
            grant_nx = '0;
            ptr_nx   = (owner == LAST_IDX) ? '0 : owner + PTR_W'(1);
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin : drop_logic
    stray_cnt = '0;
    for (int i = 0; i < NUM_INPUTS; i++) stray_cnt = stray_cnt + {3'b000, stray[i]};
    drop_sum = {1'b0, drop_count} + {13'd0, stray_cnt};
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state                    <= IDLE;
      ptr                      <= '0;
      owner                    <= '0;
      grant                    <= '0;
      drop_count               <= '0;
      stream_out_valid         <= 1'b0;
      stream_out_data          <= '0;
      stream_out_startofpacket <= 1'b0;
      stream_out_endofpacket   <= 1'b0;
      stream_out_empty         <= '0;
    end else begin
      state      <= state_nx;
      ptr        <= ptr_nx;
      owner      <= owner_nx;
      grant      <= grant_nx;
      drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      if (fwd) begin
        stream_out_valid         <= 1'b1;
        stream_out_data          <= stream_in_data[int'(owner)*DATA_WIDTH +: DATA_WIDTH];
        stream_out_startofpacket <= stream_in_startofpacket[owner];
        stream_out_endofpacket   <= stream_in_endofpacket[owner];
        stream_out_empty         <= stream_in_empty[int'(owner)*EMPTY_WIDTH +: EMPTY_WIDTH];
      end else if (stream_out_ready) begin
        stream_out_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire
